// File: rtl/itch_msg_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : itch_msg_dispatcher
// Description : ITCH front end; frames 64-bit words, decodes the message type,
//               checks length per type and keeps message/error statistics.
// Revision    : 1.0  initial release
// ============================================================================
module itch_msg_dispatcher (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] dataIn,
    input  logic        validIn,
    input  logic        sopIn,
    input  logic        eopIn,
    output logic [63:0] dataOut,
    output logic        validOut,
    output logic        eopOut,
    output logic [3:0]  counter,
    output logic        startAddOrderNoMPID,
    output logic        startAddOrderWithMPID,
    output logic        startOrderExecuted,
    output logic        startOrderDelete,
    output logic        startUnknown,
    output logic        lenError,
    output logic [15:0] msgCount,
    output logic [15:0] errCount
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_IN_MSG = 1'b1;

    // one-hot type vector bit order: {unknown, D, E, F, A}
    localparam int T_A = 0;
    localparam int T_F = 1;
    localparam int T_E = 2;
    localparam int T_D = 3;
    localparam int T_U = 4;

    logic [0:0]  state_q,   state_d;
    logic [63:0] data_q,    data_d;
    logic        valid_q,   valid_d;
    logic        eop_q,     eop_d;
    logic [3:0]  counter_q, counter_d;
    logic [4:0]  start_q,   start_d;
    logic        len_err_q, len_err_d;
    logic [15:0] msg_cnt_q, msg_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        w_accept;
    logic        w_abort;
    logic [4:0]  w_sop_type;
    logic [4:0]  w_cur_type;
    logic [3:0]  w_idx;
    logic [3:0]  w_exp_last;
    logic        w_known;
    logic        w_len_ok;
    logic        w_len_bad;

    always_comb begin
        w_accept = validIn & (sopIn | (state_q == S_IN_MSG));
        w_abort  = validIn & sopIn & (state_q == S_IN_MSG);

        w_sop_type = '0;
        case (dataIn[7:0])
            8'h41:   w_sop_type[T_A] = 1'b1;
            8'h46:   w_sop_type[T_F] = 1'b1;
            8'h45:   w_sop_type[T_E] = 1'b1;
            8'h44:   w_sop_type[T_D] = 1'b1;
            default: w_sop_type[T_U] = 1'b1;
        endcase

        w_cur_type = sopIn ? w_sop_type : start_q;
        if (sopIn)
            w_idx = 4'd0;
        else if (counter_q == 4'd15)
            w_idx = 4'd15;
        else
            w_idx = counter_q + 4'd1;

        // Index of the last word expected for each known type (length - 1)
        w_exp_last = 4'd0;
        if (w_cur_type[T_A]) w_exp_last = 4'd4;
        if (w_cur_type[T_F]) w_exp_last = 4'd5;
        if (w_cur_type[T_E]) w_exp_last = 4'd3;
        if (w_cur_type[T_D]) w_exp_last = 4'd2;
        w_known   = |w_cur_type[T_D:T_A];
        // A saturated index of 15 can never equal any expected index
        w_len_ok  = eopIn & w_known & (w_idx == w_exp_last) & (counter_q != 4'd15 || sopIn);
        w_len_bad = eopIn & w_known & ~w_len_ok;

        state_d   = state_q;
        data_d    = dataIn;
        valid_d   = w_accept;
        eop_d     = w_accept & eopIn;
        counter_d = counter_q;
        start_d   = start_q;
        len_err_d = 1'b0;
        msg_cnt_d = msg_cnt_q;
        err_cnt_d = err_cnt_q;

        if (valid_q && eop_q)
            start_d = '0;

        if (w_accept) begin
            counter_d = w_idx;
            start_d   = w_cur_type;
            state_d   = eopIn ? S_IDLE : S_IN_MSG;
            len_err_d = w_abort | w_len_bad;
            if (w_len_ok && !w_abort)
                msg_cnt_d = msg_cnt_q + 16'd1;
            if (len_err_d)
                err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            eop_q     <= 1'b0;
            counter_q <= '0;
            start_q   <= '0;
            len_err_q <= 1'b0;
            msg_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            eop_q     <= eop_d;
            counter_q <= counter_d;
            start_q   <= start_d;
            len_err_q <= len_err_d;
            msg_cnt_q <= msg_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign dataOut               = data_q;
    assign validOut              = valid_q;
    assign eopOut                = eop_q;
    assign counter               = counter_q;
    assign startAddOrderNoMPID   = start_q[T_A];
    assign startAddOrderWithMPID = start_q[T_F];
    assign startOrderExecuted    = start_q[T_E];
    assign startOrderDelete      = start_q[T_D];
    assign startUnknown          = start_q[T_U];
    assign lenError              = len_err_q;
    assign msgCount              = msg_cnt_q;
    assign errCount              = err_cnt_q;

endmodule
`default_nettype wire
